skin_bbox_locate: RTL

//  Downstream of the YCbCr skin-threshold stage. Consumes its binary mask (0 = skin) plus the

---
 rtl/skin_bbox_locate.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/skin_bbox_locate.sv
// Skin bounding-box locator: accumulates the box of skin pixels (mask == 0) over each frame,
// publishes it at the next frame edge and draws it onto the delayed RGB stream.
module skin_bbox_locate #(
    parameter int unsigned IMG_WIDTH_DATA = 24,
    parameter int unsigned COORD_W        = 11,
    parameter int unsigned CNT_W          = 21,
    parameter int unsigned MIN_PIXELS     = 64,
    parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR = 24'hFF0000
) (
    input  logic                      pixelclk,
    input  logic                      reset_n,
    input  logic [IMG_WIDTH_DATA-1:0] i_binary,
    input  logic [IMG_WIDTH_DATA-1:0] i_rgb,
    input  logic                      i_hsync,
    input  logic                      i_vsync,
    input  logic                      i_de,
    output logic [IMG_WIDTH_DATA-1:0] o_rgb,
    output logic                      o_hsync,
    output logic                      o_vsync,
    output logic                      o_de,
    output logic [COORD_W-1:0]        box_x_min,
    output logic [COORD_W-1:0]        box_x_max,
    output logic [COORD_W-1:0]        box_y_min,
    output logic [COORD_W-1:0]        box_y_max,
    output logic                      box_found,
    output logic                      box_strobe
);

    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic {ST_WAIT, ST_ACCUM} state_e;

    state_e                    state_q, state_d;
    logic [COORD_W-1:0]        x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [COORD_W-1:0]        acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
    logic [COORD_W-1:0]        acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
    logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic [COORD_W-1:0]        box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [COORD_W-1:0]        box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic                      box_found_q, box_found_d, box_strobe_q, box_strobe_d;
    logic [IMG_WIDTH_DATA-1:0] rgb_q, rgb_d;
    logic                      hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;

    logic fe_c, de_fall_c, skin_c, acc_init_c, on_border_c, found_c;
    logic in_x_c, in_y_c;

    // vsync_q / de_q double as the previous-cycle values for edge detection
    assign fe_c      = i_vsync & ~vsync_q;
    assign de_fall_c = ~i_de & de_q;
    assign skin_c    = i_de & (i_binary == '0);
    assign found_c   = (pix_cnt_q >= CNT_W'(MIN_PIXELS));

    assign in_x_c = (x_cnt_q >= box_x_min_q) && (x_cnt_q <= box_x_max_q);
    assign in_y_c = (y_cnt_q >= box_y_min_q) && (y_cnt_q <= box_y_max_q);
    assign on_border_c = (((x_cnt_q == box_x_min_q) || (x_cnt_q == box_x_max_q)) && in_y_c) ||
                         (((y_cnt_q == box_y_min_q) || (y_cnt_q == box_y_max_q)) && in_x_c);

    always_comb begin
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        acc_x_min_d  = acc_x_min_q;
        acc_x_max_d  = acc_x_max_q;
        acc_y_min_d  = acc_y_min_q;
        acc_y_max_d  = acc_y_max_q;
        pix_cnt_d    = pix_cnt_q;
        box_x_min_d  = box_x_min_q;
        box_x_max_d  = box_x_max_q;
        box_y_min_d  = box_y_min_q;
        box_y_max_d  = box_y_max_q;
        box_found_d  = box_found_q;
        box_strobe_d = 1'b0;
        acc_init_c   = 1'b0;
        hsync_d      = i_hsync;
        vsync_d      = i_vsync;
        de_d         = i_de;
        rgb_d        = '0;

        // Saturating pixel coordinates
        if (i_de) begin
            if (x_cnt_q != COORD_MAX) x_cnt_d = x_cnt_q + COORD_W'(1);
        end else if (de_fall_c) begin
            x_cnt_d = '0;
        end
        if (fe_c) begin
            y_cnt_d = '0;
        end else if (de_fall_c && (y_cnt_q != COORD_MAX)) begin
            y_cnt_d = y_cnt_q + COORD_W'(1);
        end

        if (i_de) rgb_d = (box_found_q && on_border_c) ? BOX_COLOR : i_rgb;

        case (state_q)
            ST_WAIT: begin
                if (fe_c) begin
                    state_d    = ST_ACCUM;
                    acc_init_c = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (fe_c) begin
                    box_strobe_d = 1'b1;
                    box_found_d  = found_c;
                    box_x_min_d  = found_c ? acc_x_min_q : '0;
                    box_x_max_d  = found_c ? acc_x_max_q : '0;
                    box_y_min_d  = found_c ? acc_y_min_q : '0;
                    box_y_max_d  = found_c ? acc_y_max_q : '0;
                    acc_init_c   = 1'b1;
                end else if (skin_c) begin
                    if (x_cnt_q < acc_x_min_q) acc_x_min_d = x_cnt_q;
                    if (x_cnt_q > acc_x_max_q) acc_x_max_d = x_cnt_q;
                    if (y_cnt_q < acc_y_min_q) acc_y_min_d = y_cnt_q;
                    if (y_cnt_q > acc_y_max_q) acc_y_max_d = y_cnt_q;
                    if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase

        if (acc_init_c) begin
            acc_x_min_d = COORD_MAX;
            acc_y_min_d = COORD_MAX;
            acc_x_max_d = '0;
            acc_y_max_d = '0;
            pix_cnt_d   = '0;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            acc_x_min_q  <= '1;
            acc_x_max_q  <= '0;
            acc_y_min_q  <= '1;
            acc_y_max_q  <= '0;
            pix_cnt_q    <= '0;
            box_x_min_q  <= '0;
            box_x_max_q  <= '0;
            box_y_min_q  <= '0;
            box_y_max_q  <= '0;
            box_found_q  <= 1'b0;
            box_strobe_q <= 1'b0;
            rgb_q        <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            acc_x_min_q  <= acc_x_min_d;
            acc_x_max_q  <= acc_x_max_d;
            acc_y_min_q  <= acc_y_min_d;
            acc_y_max_q  <= acc_y_max_d;
            pix_cnt_q    <= pix_cnt_d;
            box_x_min_q  <= box_x_min_d;
            box_x_max_q  <= box_x_max_d;
            box_y_min_q  <= box_y_min_d;
            box_y_max_q  <= box_y_max_d;
            box_found_q  <= box_found_d;
            box_strobe_q <= box_strobe_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
        end
    end

    assign o_rgb      = rgb_q;
    assign o_hsync    = hsync_q;
    assign o_vsync    = vsync_q;
    assign o_de       = de_q;
    assign box_x_min  = box_x_min_q;
    assign box_x_max  = box_x_max_q;
    assign box_y_min  = box_y_min_q;
    assign box_y_max  = box_y_max_q;
    assign box_found  = box_found_q;
    assign box_strobe = box_strobe_q;

endmodule
